// File: rtl/sram_ctl_pkg.sv
// Shared defaults, read-FSM encoding and a pointer-width helper for the
// SRAM-backed priority packet queue.
package sram_ctl_pkg;

  localparam int DATA_WIDTH_DEF = 256;
  localparam int NUM_PRIO_DEF   = 8;
  localparam int DEPTH_DEF      = 64;
  localparam int AF_MARGIN_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  // Index bits plus one wrap bit, so full and empty are distinguishable
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_sdp_ram.sv
// Simple dual-port storage: one write port, one read port with a registered
// (1-cycle latency) read. Contents are never reset.
module sram_sdp_ram #(
  parameter int WIDTH = 257,
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sram_prio_queue.sv
// Store-and-forward packet queue: NUM_PRIO circular queues in one SRAM,
// speculative/committed write pointers with rollback, strict-priority readout.
module sram_prio_queue
  import sram_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_PRIO   = NUM_PRIO_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_MARGIN  = AF_MARGIN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_sop,
  input  logic                        wr_eop,
  input  logic                        wr_vld,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [$clog2(NUM_PRIO)-1:0] wr_prio,
  input  logic [NUM_PRIO-1:0]         ready,
  output logic                        rd_sop,
  output logic                        rd_eop,
  output logic                        rd_vld,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [NUM_PRIO-1:0]         full,
  output logic [NUM_PRIO-1:0]         almost_full,
  output logic                        wr_drop
);

  localparam int QW  = $clog2(NUM_PRIO);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = ptr_width(DEPTH);
  localparam int RAW = QW + AW;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);
  localparam logic [PW-1:0] AF_OCC   = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] spec    [NUM_PRIO];
  logic [PW-1:0] com     [NUM_PRIO];
  logic [PW-1:0] rd_ptr  [NUM_PRIO];
  logic [PW-1:0] pkt_cnt [NUM_PRIO];
  logic [PW-1:0] spec_n  [NUM_PRIO];
  logic [PW-1:0] com_n   [NUM_PRIO];
  logic [PW-1:0] rd_n    [NUM_PRIO];
  logic [PW-1:0] cnt_n   [NUM_PRIO];

  logic            open, open_n, skip, skip_n, first, first_n;
  logic            drop_n, pop, sel_ok;
  logic [QW-1:0]   wq, wq_n, q, cur, cur_n, sel;
  rd_state_t       state, state_n;
  logic [PW-1:0]   occ_w, occ_p;
  logic [NUM_PRIO-1:0] full_n, af_n;

  logic                  mem_we;
  logic [RAW-1:0]        mem_waddr, mem_raddr;
  logic [DATA_WIDTH:0]   mem_wdata, mem_rdata;
  // Flop copy of each entry's eop bit so the FSM knows at pop time
  logic                  eop_mem [NUM_PRIO*DEPTH];

  // Write-side packet tracking, read-side FSM and next occupancy flags
  always_comb begin
    spec_n    = spec;
    com_n     = com;
    rd_n      = rd_ptr;
    cnt_n     = pkt_cnt;
    open_n    = open;
    skip_n    = skip;
    wq_n      = wq;
    q         = wq;
    drop_n    = 1'b0;
    occ_w     = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    state_n   = state;
    cur_n     = cur;
    first_n   = first;
    pop       = 1'b0;
    mem_raddr = '0;
    sel       = '0;
    sel_ok    = 1'b0;
    occ_p     = '0;
    full_n    = '0;
    af_n      = '0;

    if (wr_vld) begin
      if (wr_sop) begin
        if (open && !skip) begin
          spec_n[wq] = com[wq];
          drop_n     = 1'b1;
        end else begin
        end
        q      = wr_prio;
        wq_n   = wr_prio;
        open_n = 1'b1;
        skip_n = 1'b0;
      end else begin
      end

      if (open_n && !skip_n) begin
        occ_w = spec_n[q] - rd_ptr[q];
        if (occ_w == FULL_OCC) begin
          // Overflow: unwind the whole packet and swallow the rest of it
          spec_n[q] = com[q];
          drop_n    = 1'b1;
          open_n    = !wr_eop;
          skip_n    = !wr_eop;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = {q, spec_n[q][AW-1:0]};
          mem_wdata = {wr_eop, wr_data};
          spec_n[q] = spec_n[q] + PTR_ONE;
          if (wr_eop) begin
            com_n[q] = spec_n[q];
            cnt_n[q] = cnt_n[q] + PTR_ONE;
            open_n   = 1'b0;
          end else begin
          end
        end
      end else if (open_n && skip_n) begin
        if (wr_eop) begin
          open_n = 1'b0;
          skip_n = 1'b0;
        end else begin
        end
      end else begin
      end
    end else begin
    end

    case (state)
      IDLE: begin
        for (int p = 0; p < NUM_PRIO; p++) begin
          if ((pkt_cnt[p] != '0) && ready[p]) begin
            sel    = QW'(p);
            sel_ok = 1'b1;
          end else begin
          end
        end
        if (sel_ok) begin
          cur_n   = sel;
          first_n = 1'b1;
          state_n = SEND;
        end else begin
        end
      end
      SEND: begin
        if (ready[cur]) begin
          pop          = 1'b1;
          mem_raddr    = {cur, rd_ptr[cur][AW-1:0]};
          rd_n[cur]    = rd_ptr[cur] + PTR_ONE;
          first_n      = 1'b0;
          if (eop_mem[mem_raddr]) begin
            cnt_n[cur] = cnt_n[cur] - PTR_ONE;
            state_n    = IDLE;
          end else begin
          end
        end else begin
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    for (int p = 0; p < NUM_PRIO; p++) begin
      occ_p     = spec_n[p] - rd_n[p];
      full_n[p] = (occ_p == FULL_OCC);
      af_n[p]   = (occ_p >= AF_OCC);
    end
  end

  // Pointer, packet-count, FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec        <= '{default: '0};
      com         <= '{default: '0};
      rd_ptr      <= '{default: '0};
      pkt_cnt     <= '{default: '0};
      open        <= 1'b0;
      skip        <= 1'b0;
      wq          <= '0;
      cur         <= '0;
      first       <= 1'b0;
      state       <= IDLE;
      rd_vld      <= 1'b0;
      rd_sop      <= 1'b0;
      full        <= '0;
      almost_full <= '0;
      wr_drop     <= 1'b0;
    end else begin
      spec        <= spec_n;
      com         <= com_n;
      rd_ptr      <= rd_n;
      pkt_cnt     <= cnt_n;
      open        <= open_n;
      skip        <= skip_n;
      wq          <= wq_n;
      cur         <= cur_n;
      first       <= first_n;
      state       <= state_n;
      rd_vld      <= pop;
      rd_sop      <= pop & first;
      full        <= full_n;
      almost_full <= af_n;
      wr_drop     <= drop_n;
    end
  end

  // Eop shadow follows the RAM writes; like the RAM it is not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      eop_mem[mem_waddr] <= wr_eop;
    end
  end

  // RAM read data is only meaningful while the registered valid is high
  assign rd_data = rd_vld ? mem_rdata[DATA_WIDTH-1:0] : '0;
  assign rd_eop  = rd_vld & mem_rdata[DATA_WIDTH];

  sram_sdp_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .WORDS (NUM_PRIO * DEPTH),
    .AW    (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (pop),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_sram_prio_queue.sv
// Scenario-driven bench for sram_prio_queue with a per-priority FIFO-of-packets
// reference model and a read-side monitor.
module tb_sram_prio_queue;

  localparam int DW = 256, NP = 8, DEPTH = 64, AFM = 8, QW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_sop = 1'b0, wr_eop = 1'b0, wr_vld = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [QW-1:0] wr_prio = '0;
  logic [NP-1:0] ready = '0;
  logic          rd_sop, rd_eop, rd_vld, wr_drop;
  logic [DW-1:0] rd_data;
  logic [NP-1:0] full, almost_full;

  sram_prio_queue #(.DATA_WIDTH(DW), .NUM_PRIO(NP), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_data(wr_data), .wr_prio(wr_prio), .ready(ready),
    .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data),
    .full(full), .almost_full(almost_full), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  word_t mon_q[$];
  int    mon_cyc[$];
  word_t model_q[NP][$];
  word_t exp_q[$];
  int    cyc = 0, drop_cnt = 0, checks = 0, failures = 0;

  // Read-side monitor and drop-pulse counter, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (rd_vld) begin
        mon_q.push_back('{sop: rd_sop, eop: rd_eop, data: rd_data});
        mon_cyc.push_back(cyc);
      end
      if (wr_drop) drop_cnt = drop_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic send_pkt(input int prio, input int len, input bit close);
    word_t pend[$];
    for (int i = 0; i < len; i++) begin
      wr_vld  = 1'b1;
      wr_sop  = (i == 0);
      wr_eop  = close && (i == len - 1);
      wr_prio = (i == 0) ? QW'(prio) : QW'($urandom);
      wr_data = rand_word();
      pend.push_back('{sop: (i == 0), eop: wr_eop, data: wr_data});
      @(posedge clk); #1;
    end
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    if (close) foreach (pend[i]) model_q[prio].push_back(pend[i]);
  endtask

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      if (mon_q.size() >= n) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  // Strict priority with FIFO order inside each priority, everything pre-committed
  task automatic build_exp_by_prio();
    for (int p = NP - 1; p >= 0; p--) begin
      foreach (model_q[p][i]) exp_q.push_back(model_q[p][i]);
      model_q[p].delete();
    end
  endtask

  task automatic clear_all();
    mon_q.delete(); mon_cyc.delete(); exp_q.delete();
    for (int p = 0; p < NP; p++) model_q[p].delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({rd_vld, rd_sop, rd_eop, wr_drop} !== 4'b0 || rd_data !== '0 || full !== '0 || almost_full !== '0) begin
      failures++; $display("FAIL reset_hold got vld=%b sop=%b eop=%b drop=%b full=%h af=%h exp all 0", rd_vld, rd_sop, rd_eop, wr_drop, full, almost_full);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rd_vld, wr_drop} !== 2'b0 || full !== '0 || almost_full !== '0) begin
      failures++; $display("FAIL reset_release got vld=%b drop=%b full=%h af=%h exp 0", rd_vld, wr_drop, full, almost_full);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_all(); ready = 8'hFF;
    send_pkt(2, 3, 1'b1);
    build_exp_by_prio();
    wait_out(3, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got %0d words exp 3", mon_q.size()); end
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL basic_word[%0d] got sop=%b eop=%b data=%h exp sop=%b eop=%b data=%h", i, mon_q[i].sop, mon_q[i].eop, mon_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
      end
    end
    if (mon_cyc.size() >= 3) begin
      checks++;
      if (mon_cyc[2] - mon_cyc[0] !== 2) begin failures++; $display("FAIL basic_back_to_back got span=%0d exp 2", mon_cyc[2] - mon_cyc[0]); end
    end
    repeat (10) @(posedge clk); #1;
    checks++;
    if (mon_q.size() !== 3) begin failures++; $display("FAIL basic_count got %0d exp 3", mon_q.size()); end
  endtask

  task automatic test_priority(input bit random_set);
    bit ok;
    int np;
    clear_all(); ready = '0;
    if (!random_set) begin
      send_pkt(1, 4, 1'b1);
      send_pkt(6, 3, 1'b1);
    end else begin
      np = $urandom_range(4, 7);
      for (int k = 0; k < np; k++) send_pkt($urandom_range(0, NP - 1), $urandom_range(1, 6), 1'b1);
    end
    build_exp_by_prio();
    repeat (3) @(posedge clk); #1;
    ready = 8'hFF;
    wait_out(exp_q.size(), 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL prio_timeout got %0d words exp %0d", mon_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= mon_q.size()) begin failures++; $display("FAIL prio_word[%0d] got none exp data=%h", i, exp_q[i].data); end
      else if (mon_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL prio_word[%0d] got sop=%b eop=%b data=%h exp sop=%b eop=%b data=%h", i, mon_q[i].sop, mon_q[i].eop, mon_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].data);
      end
    end
  endtask

  task automatic test_no_preempt();
    bit ok;
    clear_all(); ready = 8'hFF;
    send_pkt(1, 20, 1'b1);
    wait_out(1, 40, ok);
    send_pkt(7, 3, 1'b1);
    foreach (model_q[1][i]) exp_q.push_back(model_q[1][i]);
    foreach (model_q[7][i]) exp_q.push_back(model_q[7][i]);
    wait_out(23, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL preempt_timeout got %0d words exp 23", mon_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= mon_q.size() || mon_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL preempt_word[%0d] got %s exp data=%h", i, (i < mon_q.size()) ? $sformatf("data=%h", mon_q[i].data) : "none", exp_q[i].data);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int d0;
    clear_all(); ready = '0; d0 = drop_cnt;
    send_pkt(2, 3, 1'b0);
    send_pkt(2, 2, 1'b1);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (drop_cnt - d0 !== 1) begin failures++; $display("FAIL abort_drop got %0d pulses exp 1", drop_cnt - d0); end
    build_exp_by_prio();
    ready = 8'hFF;
    wait_out(2, 40, ok);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (mon_q.size() !== 2) begin failures++; $display("FAIL abort_count got %0d exp 2", mon_q.size()); end
    for (int i = 0; i < 2 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_word[%0d] got data=%h exp data=%h", i, mon_q[i].data, exp_q[i].data); end
    end
  endtask

  task automatic test_orphan_single();
    bit ok;
    int d0;
    clear_all(); ready = 8'hFF; d0 = drop_cnt;
    for (int i = 0; i < 5; i++) begin
      wr_vld = 1'b1; wr_sop = 1'b0; wr_eop = $urandom_range(0, 1);
      wr_prio = QW'($urandom); wr_data = rand_word();
      @(posedge clk); #1;
    end
    wr_vld = 1'b0; wr_eop = 1'b0;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (mon_q.size() !== 0 || drop_cnt !== d0) begin failures++; $display("FAIL orphan got words=%0d drops=%0d exp 0 0", mon_q.size(), drop_cnt - d0); end
    send_pkt($urandom_range(0, NP - 1), 1, 1'b1);
    build_exp_by_prio();
    wait_out(1, 40, ok);
    checks++;
    if (!ok || mon_q[0] !== exp_q[0] || !mon_q[0].sop || !mon_q[0].eop) begin
      failures++; $display("FAIL single_word got %0d words exp 1 with sop=eop=1 data=%h", mon_q.size(), exp_q[0].data);
    end
  endtask

  task automatic test_fill();
    int d0;
    clear_all(); ready = '0; d0 = drop_cnt;
    for (int k = 1; k <= 70; k++) begin
      wr_vld = 1'b1; wr_sop = (k == 1); wr_eop = (k == 70);
      wr_prio = '0; wr_data = rand_word();
      @(posedge clk); #1;
      if (k <= 64) begin
        checks++;
        if (almost_full[0] !== (k >= DEPTH - AFM) || full[0] !== (k == DEPTH) || wr_drop !== 1'b0) begin
          failures++; $display("FAIL fill_flags word=%0d got af=%b full=%b drop=%b exp af=%b full=%b drop=0", k, almost_full[0], full[0], wr_drop, k >= DEPTH - AFM, k == DEPTH);
        end
      end else begin
        checks++;
        if (wr_drop !== (k == 65) || full[0] !== 1'b0 || almost_full[0] !== 1'b0) begin
          failures++; $display("FAIL overflow word=%0d got drop=%b full=%b af=%b exp drop=%b full=0 af=0", k, wr_drop, full[0], almost_full[0], k == 65);
        end
      end
    end
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (drop_cnt - d0 !== 1) begin failures++; $display("FAIL overflow_pulses got %0d exp 1", drop_cnt - d0); end
    ready = 8'hFF;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (mon_q.size() !== 0) begin failures++; $display("FAIL overflow_leak got %0d words exp 0", mon_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    clear_all(); ready = 8'hFF;
    send_pkt(3, 10, 1'b1);
    wait_out(1, 40, ok);
    wr_vld = 1'b1; wr_sop = 1'b1; wr_eop = 1'b0; wr_prio = 3'd5; wr_data = rand_word();
    @(posedge clk); #1;
    wr_sop = 1'b0; wr_data = rand_word();
    d0 = drop_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rd_vld, rd_sop, rd_eop, wr_drop} !== 4'b0 || rd_data !== '0 || full !== '0 || almost_full !== '0) begin
      failures++; $display("FAIL reset_async got vld=%b sop=%b eop=%b drop=%b data_nz=%b exp all 0", rd_vld, rd_sop, rd_eop, wr_drop, rd_data != '0);
    end
    wr_vld = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    send_pkt(4, 1, 1'b1);
    build_exp_by_prio();
    wait_out(1, 40, ok);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (mon_q.size() !== 1 || mon_q[0] !== exp_q[0] || drop_cnt !== d0) begin
      failures++; $display("FAIL post_reset got words=%0d drops=%0d exp 1 word sop=eop=1 data=%h, 0 drops", mon_q.size(), drop_cnt - d0, exp_q[0].data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority(1'b0);
    test_priority(1'b1);
    test_priority(1'b1);
    test_no_preempt();
    test_abort();
    test_orphan_single();
    test_fill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_prio_queue.md
SRAM_PRIO_QUEUE -- requirements
Module: sram_prio_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, meaning the width of a data word.
REQ-002 SHALL have parameter NUM_PRIO, default 8, meaning the number of priority queues; index NUM_PRIO-1 is the highest priority.
REQ-003 SHALL have parameter DEPTH, default 64, meaning words per queue; it SHALL be a power of 2 and at least 4.
REQ-004 SHALL have parameter AF_MARGIN, default 8, meaning the almost_full threshold measured from full; legal range 1..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have ports wr_sop, wr_eop, wr_vld, each input, 1 bit: write-side packet start, packet end and word valid.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH bits: the write word.
REQ-009 SHALL have port wr_prio, input, $clog2(NUM_PRIO) bits: the target queue, sampled only on an sop word.
REQ-010 SHALL have port ready, input, NUM_PRIO bits: downstream acceptance, one bit per priority.
REQ-011 SHALL have ports rd_sop, rd_eop, rd_vld, each output reg, 1 bit: read-side packet start, packet end and word valid.
REQ-012 SHALL have port rd_data, output reg, DATA_WIDTH bits: the read word.
REQ-013 SHALL have ports full and almost_full, each output reg, NUM_PRIO bits: per-queue occupancy flags.
REQ-014 SHALL have port wr_drop, output reg, 1 bit: a one-cycle pulse when a packet is discarded.

Function
REQ-015 SHALL store each queue as a circular buffer of DEPTH entries, each holding {eop, data}.
REQ-016 SHALL latch wr_prio on a cycle with wr_vld=1 and wr_sop=1, and SHALL write all words of that packet to the latched queue.
REQ-017 SHALL discard, without a wr_drop pulse, any word with wr_vld=1 that arrives outside a packet (no preceding sop).
REQ-018 SHALL treat a cycle with wr_vld=1 and both wr_sop=1 and wr_eop=1 as a complete single-word packet.
REQ-019 SHALL treat an sop arriving while a packet is open as an abort of the open packet (rollback and wr_drop), followed by the start of a new packet.
REQ-020 SHALL write each word at the queue's speculative write pointer, and SHALL copy that pointer to the committed write pointer and increment the queue's pkt_cnt only on the eop word.
REQ-021 SHALL, when a word targets a full queue, drop that word, roll the speculative pointer back to the committed pointer, discard the remaining words up to and including eop, and pulse wr_drop exactly once in the cycle after the overflowing word.
REQ-022 SHALL compute occupancy as speculative write pointer minus read pointer, using $clog2(DEPTH)+1-bit pointers (wrap bit included).
REQ-023 SHALL assert full[p] exactly when occupancy equals DEPTH, and almost_full[p] when occupancy is at least DEPTH-AF_MARGIN.
REQ-024 SHALL register full and almost_full, so both reflect state one cycle after the causing write, read or rollback.
REQ-025 SHALL use read FSM states IDLE and SEND.
REQ-026 SHALL, in IDLE, select the highest p with pkt_cnt[p]>0 and ready[p]=1, latch it as cur, and enter SEND; if no p qualifies it SHALL stay in IDLE.
REQ-027 SHALL, in SEND, pop one word from queue cur on every cycle with ready[cur]=1 and stall while ready[cur]=0; a higher priority SHALL NOT pre-empt a packet in flight.
REQ-028 SHALL, on popping the eop word, decrement pkt_cnt[cur] and return to IDLE, leaving at least one IDLE cycle between packets.
REQ-029 SHALL present a popped word on rd_data/rd_vld exactly one cycle after the pop, with rd_sop on the first word of the packet, rd_eop on the stored eop word, and rd_vld=0 otherwise.
REQ-030 SHALL read only committed packets, so store-and-forward holds and a dropped packet never appears on rd_*.
REQ-031 SHALL, on a same-cycle commit and pop-of-eop on one queue, leave pkt_cnt unchanged and update occupancy by +1-1.

Reset
REQ-032 SHALL, while rst=1, immediately clear all pointers, pkt_cnt, the open-packet state and cur, and force the FSM to IDLE.
REQ-033 SHALL hold rd_sop, rd_eop, rd_vld, rd_data, full, almost_full and wr_drop at 0 during reset.
REQ-034 SHALL silently lose any partial packet in flight at reset (no wr_drop) and SHALL NOT reset the memory contents.

Structure
REQ-035 SHALL take parameter defaults and the FSM state encoding (IDLE, SEND) from the shared package sram_ctl_pkg.
REQ-036 SHALL place storage in one sub-module, sram_sdp_ram: simple dual-port, NUM_PRIO*DEPTH x (DATA_WIDTH+1), synchronous read with 1-cycle latency.

Verification
REQ-037 SHALL verify: 3-word packet at prio 2, ready=8'hFF -> rd_vld for 3 cycles starting 1 cycle after pop, rd_sop on word0 only, rd_eop on word2 only, data in order.
REQ-038 SHALL verify: packets committed at prio 1 and prio 6, ready=8'hFF -> the prio 6 packet is output completely before any prio 1 word.
REQ-039 SHALL verify: prio 1 packet in SEND, then a prio 7 packet commits -> the prio 1 packet finishes uninterrupted, then prio 7 is sent.
REQ-040 SHALL verify: DEPTH=64, AF_MARGIN=8, ready=0, fill queue 0 -> almost_full[0] rises after word 56, full[0] after word 64; word 65 of a 70-word packet -> wr_drop pulses once and occupancy returns to the pre-packet value.
REQ-041 SHALL verify: rst asserted mid-write and mid-read -> all outputs 0 immediately, and a subsequent 1-word packet passes with correct sop/eop.
REQ-042 SHALL verify: wr_vld words without sop -> no storage, no wr_drop; single-word sop+eop packet -> output with rd_sop=rd_eop=1.
